stream_serializer: RTL and testbench

Width-downconverting source stage for the valid/ready streaming fabric. It accepts one wide word of `ratio_p` packed beats on its input handshake and transmits those beats one per cycle on a narrow output valid/ready handshake. An end-of-word marker accompanies the final beat. It sits between wide producers (packed pixel words, filter outputs) and narrow consumers (byte links, single-pixel pipelines), and drives the same handshake the elastic pipeline stages accept.

---
 rtl/stream_serializer_if.sv | 36 +++
 rtl/stream_serializer.sv | 105 ++++++++++
 tb/tb_stream_serializer.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_serializer_if.sv
// stream_serializer_if: wide-word in, narrow-beat out valid/ready bundle.
// Ports: data_i/valid_i/ready_o (word side), data_o/valid_o/last_o/ready_i (beat side).
interface stream_serializer_if #(
    parameter int width_p = 8,
    parameter int ratio_p = 4
);
    logic [width_p*ratio_p-1:0] data_i;
    logic                       valid_i;
    logic                       ready_o;
    logic                       valid_o;
    logic [width_p-1:0]         data_o;
    logic                       last_o;
    logic                       ready_i;

    // master: the environment (word producer and beat consumer)
    modport master (
        output data_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o,
        input  last_o
    );

    // slave: the serializer itself
    modport slave (
        input  data_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o,
        output last_o
    );
endinterface

// File: rtl/stream_serializer.sv
// stream_serializer: splits one width_p*ratio_p word into ratio_p beats.
// Ports: clk_i, reset_ni (async active-low), bus (stream_serializer_if.slave).
module stream_serializer #(
    parameter int width_p     = 8,
    parameter int ratio_p     = 4,
    parameter int lsb_first_p = 1
) (
    input  logic clk_i,
    input  logic reset_ni,
    stream_serializer_if.slave bus
);
    localparam int word_w  = width_p * ratio_p;
    localparam int count_w = (ratio_p > 1) ? $clog2(ratio_p) : 1;
    localparam logic [count_w-1:0] last_idx = count_w'(ratio_p - 1);

    typedef enum logic {
        empty_s,
        busy_s
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [word_w-1:0]   data_r;
    logic [word_w-1:0]   data_n;
    logic [word_w-1:0]   shifted;
    logic [count_w-1:0]  count_r;
    logic [count_w-1:0]  count_n;
    logic [width_p-1:0]  beat;
    logic                valid;
    logic                last;
    logic                ready;
    logic                in_fire;
    logic                out_fire;

    // The emitting end is fixed by lsb_first_p; the shift always moves
    // the next beat toward that end and back-fills with zeros.
    always_comb begin
        if (lsb_first_p != 0) begin
            beat    = data_r[width_p-1:0];
            shifted = data_r >> width_p;
        end else begin
            beat    = data_r[word_w-1 -: width_p];
            shifted = data_r << width_p;
        end
    end

    always_comb begin
        valid    = (state == busy_s);
        last     = valid && (count_r == last_idx);
        // Refill only in the same cycle the final beat leaves, so a
        // continuous stream runs without a bubble between words.
        ready    = reset_ni && ((state == empty_s) || (last && bus.ready_i));
        in_fire  = bus.valid_i && ready;
        out_fire = valid && bus.ready_i;
    end

    always_comb begin
        state_n = state;
        data_n  = data_r;
        count_n = count_r;
        unique case (state)
            empty_s: begin
                if (in_fire) begin
                    data_n  = bus.data_i;
                    count_n = '0;
                    state_n = busy_s;
                end
            end
            busy_s: begin
                if (out_fire) begin
                    if (!last) begin
                        data_n  = shifted;
                        count_n = count_r + 1'b1;
                    end else if (in_fire) begin
                        data_n  = bus.data_i;
                        count_n = '0;
                    end else begin
                        // the final shift leaves data_r all zero
                        data_n  = shifted;
                        count_n = '0;
                        state_n = empty_s;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= empty_s;
            data_r  <= '0;
            count_r <= '0;
        end else begin
            state   <= state_n;
            data_r  <= data_n;
            count_r <= count_n;
        end
    end

    assign bus.valid_o = valid;
    assign bus.last_o  = last;
    assign bus.data_o  = beat;
    assign bus.ready_o = ready;

endmodule

// File: tb/tb_stream_serializer.sv
// tb_stream_serializer: directed and randomized checks of stream_serializer
// over several ratio / beat-order configurations with a beat scoreboard.
module tb_stream_serializer;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    stream_serializer_if #(.width_p(8), .ratio_p(4))  u4  ();
    stream_serializer_if #(.width_p(8), .ratio_p(4))  m4  ();
    stream_serializer_if #(.width_p(8), .ratio_p(2))  r2  ();
    stream_serializer_if #(.width_p(8), .ratio_p(3))  r3  ();
    stream_serializer_if #(.width_p(8), .ratio_p(16)) r16 ();

    stream_serializer #(.width_p(8), .ratio_p(4), .lsb_first_p(1)) dut_u4 (
        .clk_i(clk), .reset_ni(reset_ni), .bus(u4));
    stream_serializer #(.width_p(8), .ratio_p(4), .lsb_first_p(0)) dut_m4 (
        .clk_i(clk), .reset_ni(reset_ni), .bus(m4));
    stream_serializer #(.width_p(8), .ratio_p(2), .lsb_first_p(1)) dut_r2 (
        .clk_i(clk), .reset_ni(reset_ni), .bus(r2));
    stream_serializer #(.width_p(8), .ratio_p(3), .lsb_first_p(0)) dut_r3 (
        .clk_i(clk), .reset_ni(reset_ni), .bus(r3));
    stream_serializer #(.width_p(8), .ratio_p(16), .lsb_first_p(1)) dut_r16 (
        .clk_i(clk), .reset_ni(reset_ni), .bus(r16));

    localparam int rat  [5] = '{4, 4, 2, 3, 16};
    localparam int lsbf [5] = '{1, 0, 1, 0, 1};

    logic [127:0] din   [5];
    logic [7:0]   dout  [5];
    logic         vin   [5];
    logic         rdy_o [5];
    logic         vo    [5];
    logic         lo    [5];
    logic         rin   [5];

    assign din[0] = 128'(u4.data_i);
    assign din[1] = 128'(m4.data_i);
    assign din[2] = 128'(r2.data_i);
    assign din[3] = 128'(r3.data_i);
    assign din[4] = r16.data_i;
    assign dout[0] = u4.data_o;  assign dout[1] = m4.data_o;
    assign dout[2] = r2.data_o;  assign dout[3] = r3.data_o;
    assign dout[4] = r16.data_o;
    assign vin[0] = u4.valid_i;  assign vin[1] = m4.valid_i;
    assign vin[2] = r2.valid_i;  assign vin[3] = r3.valid_i;
    assign vin[4] = r16.valid_i;
    assign rdy_o[0] = u4.ready_o;  assign rdy_o[1] = m4.ready_o;
    assign rdy_o[2] = r2.ready_o;  assign rdy_o[3] = r3.ready_o;
    assign rdy_o[4] = r16.ready_o;
    assign vo[0] = u4.valid_o;  assign vo[1] = m4.valid_o;
    assign vo[2] = r2.valid_o;  assign vo[3] = r3.valid_o;
    assign vo[4] = r16.valid_o;
    assign lo[0] = u4.last_o;  assign lo[1] = m4.last_o;
    assign lo[2] = r2.last_o;  assign lo[3] = r3.last_o;
    assign lo[4] = r16.last_o;
    assign rin[0] = u4.ready_i;  assign rin[1] = m4.ready_i;
    assign rin[2] = r2.ready_i;  assign rin[3] = r3.ready_i;
    assign rin[4] = r16.ready_i;

    // scoreboard entries are {last, beat}
    logic [8:0] sb    [5][$];
    logic       stall [5];
    logic [8:0] held  [5];
    logic [8:0] exp_e;

    // Inputs change 1 time unit after posedge, so values seen at the
    // negedge are exactly what the next posedge will transfer.
    always @(negedge clk) begin
        if (!reset_ni) begin
            for (int i = 0; i < 5; i++) begin
                sb[i].delete();
                stall[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (stall[i]) begin
                    total++;
                    if (vo[i] !== 1'b1 || {lo[i], dout[i]} !== held[i]) begin
                        bad++;
                        $display("FAIL stall_hold[%0d] got v=%b %h want v=1 %h",
                                 i, vo[i], {lo[i], dout[i]}, held[i]);
                    end
                end
                stall[i] = (vo[i] === 1'b1) && (rin[i] === 1'b0);
                held[i]  = {lo[i], dout[i]};
                if (vo[i] === 1'b1 && rin[i] === 1'b1) begin
                    total++;
                    if (sb[i].size() == 0) begin
                        bad++;
                        $display("FAIL extra_beat[%0d] got %h want none",
                                 i, {lo[i], dout[i]});
                    end else begin
                        exp_e = sb[i].pop_front();
                        if ({lo[i], dout[i]} !== exp_e) begin
                            bad++;
                            $display("FAIL sb_beat[%0d] got %h want %h",
                                     i, {lo[i], dout[i]}, exp_e);
                        end
                    end
                end
                if (vin[i] === 1'b1 && rdy_o[i] === 1'b1) begin
                    for (int k = 0; k < rat[i]; k++) begin
                        int b;
                        b = (lsbf[i] != 0) ? k : rat[i] - 1 - k;
                        sb[i].push_back({k == rat[i] - 1, din[i][b*8 +: 8]});
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        u4.valid_i = 1'b0;  u4.ready_i = 1'b1;  u4.data_i = '0;
        m4.valid_i = 1'b0;  m4.ready_i = 1'b1;  m4.data_i = '0;
        r2.valid_i = 1'b0;  r2.ready_i = 1'b1;  r2.data_i = '0;
        r3.valid_i = 1'b0;  r3.ready_i = 1'b1;  r3.data_i = '0;
        r16.valid_i = 1'b0; r16.ready_i = 1'b1; r16.data_i = '0;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        idle_all();
        u4.valid_i = 1'b1;
        u4.data_i = 32'h12345678;
        #2;
        total++;
        if ({u4.valid_o, u4.ready_o, u4.last_o, u4.data_o} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b r=%b l=%b d=%h want all 0",
                     u4.valid_o, u4.ready_o, u4.last_o, u4.data_o);
        end
        total++;
        if (dut_u4.count_r !== 2'd0) begin
            bad++;
            $display("FAIL reset_count got %0d want 0", dut_u4.count_r);
        end
        u4.valid_i = 1'b0;
        cyc();
        cyc();
        reset_ni = 1'b1;
        #1;
        total++;
        if (u4.ready_o !== 1'b1 || u4.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL release_ready got r=%b v=%b want r=1 v=0",
                     u4.ready_o, u4.valid_o);
        end
        cyc();
    endtask

    task automatic test_lsb_first();
        logic [7:0] e [4];
        e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        u4.data_i = 32'hDDCCBBAA;
        u4.valid_i = 1'b1;
        cyc();
        u4.valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (u4.valid_o !== 1'b1 || u4.data_o !== e[k] ||
                u4.last_o !== (k == 3) || u4.ready_o !== (k == 3)) begin
                bad++;
                $display("FAIL lsb_beat%0d got v=%b d=%h l=%b r=%b want v=1 d=%h l=%b r=%b",
                         k, u4.valid_o, u4.data_o, u4.last_o, u4.ready_o,
                         e[k], k == 3, k == 3);
            end
            cyc();
        end
        total++;
        if (u4.valid_o !== 1'b0 || u4.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL lsb_drain got v=%b r=%b want v=0 r=1",
                     u4.valid_o, u4.ready_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        u4.data_i = 32'h44332211;
        u4.valid_i = 1'b1;
        cyc();
        u4.data_i = 32'h88776655;
        for (int k = 0; k < 8; k++) begin
            e = 8'((k + 1) * 17);
            #1;
            total++;
            if (u4.valid_o !== 1'b1 || u4.data_o !== e ||
                u4.ready_o !== (k == 3 || k == 7) ||
                u4.last_o !== (k == 3 || k == 7)) begin
                bad++;
                $display("FAIL b2b_beat%0d got v=%b d=%h r=%b l=%b want v=1 d=%h r=%b",
                         k, u4.valid_o, u4.data_o, u4.ready_o, u4.last_o,
                         e, k == 3 || k == 7);
            end
            if (k == 4) u4.valid_i = 1'b0;
            cyc();
        end
        total++;
        if (u4.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain got v=%b want 0", u4.valid_o);
        end
    endtask

    task automatic test_backpressure();
        u4.data_i = 32'hDDCCBBAA;
        u4.valid_i = 1'b1;
        cyc();
        u4.valid_i = 1'b0;
        cyc();
        u4.ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (u4.valid_o !== 1'b1 || u4.data_o !== 8'hBB ||
                u4.ready_o !== 1'b0 || u4.last_o !== 1'b0 ||
                dut_u4.count_r !== 2'd1) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b d=%h r=%b cnt=%0d want v=1 d=bb r=0 cnt=1",
                         k, u4.valid_o, u4.data_o, u4.ready_o, dut_u4.count_r);
            end
            cyc();
        end
        u4.ready_i = 1'b1;
        cyc();
        total++;
        if (u4.data_o !== 8'hCC || u4.valid_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_resume_cc got v=%b d=%h want v=1 d=cc",
                     u4.valid_o, u4.data_o);
        end
        cyc();
        total++;
        if (u4.data_o !== 8'hDD || u4.last_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_resume_dd got d=%h l=%b want d=dd l=1",
                     u4.data_o, u4.last_o);
        end
        cyc();
    endtask

    task automatic test_msb_first();
        logic [7:0] e [4];
        e = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        m4.data_i = 32'hDDCCBBAA;
        m4.valid_i = 1'b1;
        cyc();
        m4.valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (m4.valid_o !== 1'b1 || m4.data_o !== e[k] ||
                m4.last_o !== (k == 3)) begin
                bad++;
                $display("FAIL msb_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, m4.valid_o, m4.data_o, m4.last_o, e[k], k == 3);
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid_word();
        u4.data_i = 32'hDDCCBBAA;
        u4.valid_i = 1'b1;
        cyc();
        u4.valid_i = 1'b0;
        cyc();
        reset_ni = 1'b0;
        #1;
        total++;
        if ({u4.valid_o, u4.ready_o, u4.last_o, u4.data_o} !== 11'h0) begin
            bad++;
            $display("FAIL midreset_outputs got v=%b r=%b l=%b d=%h want all 0",
                     u4.valid_o, u4.ready_o, u4.last_o, u4.data_o);
        end
        cyc();
        reset_ni = 1'b1;
        #1;
        total++;
        if (u4.ready_o !== 1'b1 || u4.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_release got r=%b v=%b want r=1 v=0",
                     u4.ready_o, u4.valid_o);
        end
        u4.data_i = 32'h0A0B0C0D;
        u4.valid_i = 1'b1;
        cyc();
        u4.valid_i = 1'b0;
        total++;
        if (u4.data_o !== 8'h0D || u4.valid_o !== 1'b1) begin
            bad++;
            $display("FAIL midreset_first got v=%b d=%h want v=1 d=0d",
                     u4.valid_o, u4.data_o);
        end
        repeat (5) cyc();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            u4.valid_i = 1'($urandom_range(0, 1));
            u4.ready_i = 1'($urandom_range(0, 1));
            u4.data_i = $urandom;
            m4.valid_i = 1'($urandom_range(0, 1));
            m4.ready_i = 1'($urandom_range(0, 1));
            m4.data_i = $urandom;
            r2.valid_i = 1'($urandom_range(0, 1));
            r2.ready_i = 1'($urandom_range(0, 1));
            r2.data_i = 16'($urandom);
            r3.valid_i = 1'($urandom_range(0, 1));
            r3.ready_i = 1'($urandom_range(0, 1));
            r3.data_i = 24'($urandom);
            r16.valid_i = 1'($urandom_range(0, 3) != 0);
            r16.ready_i = 1'($urandom_range(0, 3) != 0);
            r16.data_i = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        idle_all();
        repeat (40) cyc();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (sb[i].size() != 0) begin
                bad++;
                $display("FAIL random_drain[%0d] got %0d pending want 0",
                         i, sb[i].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_back_to_back();
        test_backpressure();
        test_msb_first();
        test_reset_mid_word();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
